hdlc_tx_scheduler: RTL

Arbitrates N byte-stream requesters for the single HDLC transmitter and sequences each granted frame into it. Byte by byte, it loads the frame into the Tx buffer over the HDLC register bus (Address/Data_In/WriteEnable). It then writes Tx_Enable, waits for transmission to complete, and handles requester aborts, buffer overflow and a stuck-transmitter watchdog. It sits between the host-side frame sources and the HDLC register interface.

---
 rtl/hdlc_pkg.sv | 34 +++
 rtl/hdlc_tx_scheduler_rr_arbiter.sv | 40 ++++
 rtl/hdlc_tx_scheduler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdlc_pkg.sv
// -----------------------------------------------------------------------------
// hdlc_pkg
// Shared definitions for the HDLC transmit scheduler:
//   - HDLC register addresses (Tx_SC control/status, Tx_Buff data)
//   - Tx_SC command bit positions and the command bytes built from them
//   - scheduler FSM state encoding
// -----------------------------------------------------------------------------
package hdlc_pkg;

  localparam logic [2:0] TX_SC_ADDR   = 3'd0;
  localparam logic [2:0] TX_BUFF_ADDR = 3'd1;

  localparam int unsigned TX_ENABLE_BIT     = 32'd1;
  localparam int unsigned TX_ABORTFRAME_BIT = 32'd2;

  // Builds a Tx_SC write value with a single command bit set.
  function automatic logic [7:0] tx_sc_cmd(input int unsigned bit_pos);
    return 8'd1 << bit_pos;
  endfunction

  localparam logic [7:0] TX_SC_ENABLE = tx_sc_cmd(TX_ENABLE_BIT);     // 8'h02
  localparam logic [7:0] TX_SC_ABORT  = tx_sc_cmd(TX_ABORTFRAME_BIT); // 8'h04

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    DRAIN     = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4,
    ABORT     = 3'd5,
    RESP      = 3'd6
  } tx_sched_state_t;

endpackage

// File: rtl/hdlc_tx_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Stateless round-robin arbiter. The search starts at (last_owner_i + 1)
// modulo N_REQ and wraps; the first active request wins.
// Ports:
//   req_i        request vector
//   last_owner_i index of the previous owner (held by the caller)
//   en_i         when low the grant is all-zero
//   grant_o      one-hot grant, all-zero if disabled or no request
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_owner_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] grant_o
);

  int   idx_s;
  logic found_s;

  // Rotating priority search, first hit after the previous owner.
  always_comb begin
    grant_o = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx_s = (int'(last_owner_i) + k) % N_REQ;
      if (en_i && !found_s && req_i[IDX_W'(idx_s)]) begin
        grant_o[IDX_W'(idx_s)] = 1'b1;
        found_s                = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/hdlc_tx_scheduler.sv
// -----------------------------------------------------------------------------
// hdlc_tx_scheduler
// Arbitrates N_REQ byte-stream requesters for one HDLC transmitter, copies
// the granted frame byte by byte into Tx_Buff, starts transmission, waits
// for completion and reports Done/Error to the owner. Handles requester
// abort, Tx buffer overflow and a stuck-transmitter watchdog.
// Ports:
//   Clk, Rst                 clock, asynchronous active-low reset
//   Req_Valid/Data/Last/Abort requester byte stream and abort level
//   Req_Ready                byte accepted when Valid && Ready (owner only)
//   Grant                    one-hot current owner, zero when idle
//   Req_Done/Req_Error       one-cycle completion pulse and its error flag
//   Address/Data_In/WriteEnable  registered HDLC register write bus
//   Tx_Done, Tx_AbortedTrans HDLC transmitter status
// -----------------------------------------------------------------------------
module hdlc_tx_scheduler
  import hdlc_pkg::*;
#(
  parameter int          N_REQ     = 2,
  parameter int          MAX_FRAME = 126,
  parameter logic [15:0] TIMEOUT   = 16'd65535
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [N_REQ-1:0]   Req_Valid,
  input  logic [N_REQ*8-1:0] Req_Data,
  input  logic [N_REQ-1:0]   Req_Last,
  input  logic [N_REQ-1:0]   Req_Abort,
  output logic [N_REQ-1:0]   Req_Ready,
  output logic [N_REQ-1:0]   Grant,
  output logic [N_REQ-1:0]   Req_Done,
  output logic [N_REQ-1:0]   Req_Error,
  output logic [2:0]         Address,
  output logic [7:0]         Data_In,
  output logic               WriteEnable,
  input  logic               Tx_Done,
  input  logic               Tx_AbortedTrans
);

  localparam int         IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [6:0] MAX_CNT   = 7'(MAX_FRAME);
  localparam logic [15:0] WD_LAST  = TIMEOUT - 16'd1;

  tx_sched_state_t  state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] error_q, error_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_owner_q, last_owner_d;
  logic [6:0]       count_q, count_d;
  logic             err_q, err_d;
  logic [15:0]      wd_q, wd_d;
  logic [2:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             we_q, we_d;
  logic             txd_prev_q;

  logic [N_REQ-1:0] arb_grant_s;
  logic [IDX_W-1:0] arb_idx_s;
  logic             own_acc_s;
  logic             own_last_s;
  logic             own_abort_s;
  logic [7:0]       own_data_s;
  logic             tx_rise_s;
  logic             wd_expired_s;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i        (Req_Valid),
    .last_owner_i (last_owner_q),
    .en_i         ((state_q == IDLE) && Tx_Done),
    .grant_o      (arb_grant_s)
  );

  // One-hot arbiter grant to owner index.
  always_comb begin
    arb_idx_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant_s[IDX_W'(i)]) begin
        arb_idx_s = IDX_W'(i);
      end else begin
        arb_idx_s = arb_idx_s;
      end
    end
  end

  // Owner-side views; non-owner inputs never reach the FSM.
  always_comb begin
    own_acc_s    = Req_Valid[owner_q] & ready_q[owner_q];
    own_last_s   = Req_Last[owner_q];
    own_abort_s  = Req_Abort[owner_q];
    own_data_s   = Req_Data[{owner_q, 3'b000} +: 8];
    tx_rise_s    = Tx_Done & ~txd_prev_q;
    // wd_q counts WAIT_DONE cycles already spent; this is the TIMEOUT-th one.
    wd_expired_s = (wd_q == WD_LAST);
  end

  // Scheduler next-state, bus write and handshake decode.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    count_d      = count_q;
    err_d        = err_q;
    wd_d         = wd_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = 1'b0;
    done_d       = '0;
    error_d      = '0;
    ready_d      = '0;

    case (state_q)
      IDLE: begin
        if (Tx_Done && (|Req_Valid)) begin
          grant_d = arb_grant_s;
          owner_d = arb_idx_s;
          count_d = 7'd0;
          err_d   = 1'b0;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // Abort wins over a byte offered in the same cycle.
        if (own_abort_s) begin
          we_d    = 1'b1;
          addr_d  = TX_SC_ADDR;
          data_d  = TX_SC_ABORT;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (own_acc_s) begin
          if (count_q == MAX_CNT) begin
            we_d    = 1'b1;
            addr_d  = TX_SC_ADDR;
            data_d  = TX_SC_ABORT;
            err_d   = 1'b1;
            state_d = own_last_s ? RESP : DRAIN;
          end else begin
            we_d    = 1'b1;
            addr_d  = TX_BUFF_ADDR;
            data_d  = own_data_s;
            count_d = count_q + 7'd1;
            state_d = own_last_s ? START : LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      DRAIN: begin
        if (own_acc_s && own_last_s) begin
          state_d = RESP;
        end else begin
          state_d = DRAIN;
        end
      end
      START: begin
        we_d    = 1'b1;
        addr_d  = TX_SC_ADDR;
        data_d  = TX_SC_ENABLE;
        wd_d    = 16'd0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (own_abort_s || wd_expired_s) begin
          we_d    = 1'b1;
          addr_d  = TX_SC_ADDR;
          data_d  = TX_SC_ABORT;
          state_d = ABORT;
        end else if (Tx_AbortedTrans) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (tx_rise_s) begin
          state_d = RESP;
        end else begin
          wd_d    = (wd_q == 16'hFFFF) ? wd_q : (wd_q + 16'd1);
          state_d = WAIT_DONE;
        end
      end
      ABORT: begin
        if (Tx_AbortedTrans || Tx_Done) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = ABORT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    // Done/Error are registered from the transition into RESP, so they are
    // visible during the RESP cycle, at the same time Grant drops.
    if ((state_d == RESP) && (state_q != RESP)) begin
      done_d       = grant_q;
      error_d      = err_d ? grant_q : '0;
      grant_d      = '0;
      last_owner_d = owner_q;
    end else begin
      done_d  = '0;
      error_d = '0;
    end

    if ((state_d == LOAD) || (state_d == DRAIN)) begin
      ready_d = grant_d;
    end else begin
      ready_d = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ready_q      <= '0;
      done_q       <= '0;
      error_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(N_REQ - 1);
      count_q      <= 7'd0;
      err_q        <= 1'b0;
      wd_q         <= 16'd0;
      addr_q       <= 3'd0;
      data_q       <= 8'd0;
      we_q         <= 1'b0;
      txd_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      error_q      <= error_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      count_q      <= count_d;
      err_q        <= err_d;
      wd_q         <= wd_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      txd_prev_q   <= Tx_Done;
    end
  end

  assign Grant       = grant_q;
  assign Req_Ready   = ready_q;
  assign Req_Done    = done_q;
  assign Req_Error   = error_q;
  assign Address     = addr_q;
  assign Data_In     = data_q;
  assign WriteEnable = we_q;

endmodule
